// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch front end.
//   IF_RESET_PC   : default fetch PC after reset
//   IF_FIFO_DEPTH : default fetch-buffer depth and in-flight request limit
//   NOP_INSTR     : word presented to IF/ID when no instruction is available
//   fetch_entry_t : one buffered fetch, {pc, instr}
//   cnt_w()       : width of a counter that must hold 0..depth inclusive
package if_pkg;

  localparam logic [31:0] IF_RESET_PC   = 32'h0000_3000;
  localparam int          IF_FIFO_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/if_fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the fetch buffer.
//   clk, reset    : clock, asynchronous active-high reset
//   push, din     : write an entry (accepted when not full, or full with a pop)
//   pop           : retire the head entry (ignored when empty)
//   clear         : drop all entries; wins over push and pop
//   head          : current head entry (only meaningful when !empty)
//   count         : number of valid entries, 0..DEPTH
//   full, empty   : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module if_fetch_fifo
  import if_pkg::*;
#(
  parameter  int DEPTH = IF_FIFO_DEPTH,
  localparam int CW    = cnt_w(DEPTH),
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  fetch_entry_t  din,
  input  logic          pop,
  input  logic          clear,
  output fetch_entry_t  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues in-order imem reads
// over req/gnt/rvalid, buffers returns and feeds IF/ID one word per cycle.
//   clk, reset          : clock, asynchronous active-high reset
//   imem_req/addr/gnt   : request channel (addr held until gnt)
//   imem_rvalid/rdata   : in-order response channel
//   redirect/redirect_pc: branch/jump target; also flushes IF/ID
//   if_idwrite          : ID consumes the presented word this cycle
//   is/pc_plus4F/if_valid : presented instruction, its PC+4, real-word flag
//   if_misalign         : sticky misaligned-target flag (IF_MISALIGN_TRAP_EN)
// Build option: define IF_MISALIGN_TRAP_EN to trap misaligned redirect
// targets; otherwise redirect_pc[1:0] is ignored.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = IF_RESET_PC,
  parameter int          FIFO_DEPTH = IF_FIFO_DEPTH
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        if_idwrite,
  output logic [31:0] is,
  output logic [31:0] pc_plus4F,
  output logic        if_valid
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        if_misalign
`endif
);

  localparam int             CW    = cnt_w(FIFO_DEPTH);
  localparam int             AW    = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]    LIMIT = (CW+1)'(FIFO_DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   target;
  logic [CW-1:0] outstanding, drop, out_next;
  logic [31:0]   pcq [FIFO_DEPTH];
  logic [AW-1:0] pcq_wr, pcq_rd;
  logic          grant, ret, ret_keep, id_pop, halt;

  fetch_entry_t  ret_entry, fifo_head;
  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;

  assign target = {redirect_pc[31:2], 2'b00};

`ifdef IF_MISALIGN_TRAP_EN
  // A misaligned target parks fetch until a clean redirect arrives.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         halt <= 1'b0;
    else if (redirect) halt <= (redirect_pc[1:0] != 2'b00);
  end
  assign if_misalign = halt;
`else
  logic unused_rpc_lsb;
  assign unused_rpc_lsb = ^redirect_pc[1:0];
  assign halt = 1'b0;
`endif

  assign grant    = imem_req && imem_gnt;
  // Responses with nothing in flight (e.g. left over from before reset) are ignored.
  assign ret      = imem_rvalid && (outstanding != '0);
  // Stale returns from before a redirect are counted off by drop.
  assign ret_keep = ret && (drop == '0);
  assign id_pop   = if_idwrite && !fifo_empty && !redirect;
  assign out_next = outstanding + CW'(grant) - CW'(ret);

  // Buffered plus in-flight words never exceed the buffer, so every
  // return has a slot waiting for it.
  assign imem_req  = !reset && !redirect && !halt && !fifo_full &&
                     (({1'b0, fifo_count} + {1'b0, outstanding}) < LIMIT);
  assign imem_addr = fpc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fpc         <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      outstanding <= out_next;
      if (redirect) begin
        // Everything still in flight after this cycle is now stale.
        fpc    <= target;
        drop   <= out_next;
        pcq_wr <= '0;
        pcq_rd <= '0;
      end else begin
        if (grant) begin
          fpc    <= fpc + 32'd4;
          pcq_wr <= pcq_wr + AW'(1);
        end
        if (ret && (drop != '0)) drop   <= drop - CW'(1);
        if (ret_keep)            pcq_rd <= pcq_rd + AW'(1);
      end
    end
  end

  // In-flight PC queue: pairs each kept return with the address that made it.
  always_ff @(posedge clk) begin
    if (grant) pcq[pcq_wr] <= fpc;
  end

  assign ret_entry = '{pc: pcq[pcq_rd], instr: imem_rdata};

  if_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (ret_keep),
    .din   (ret_entry),
    .pop   (id_pop),
    .clear (redirect),
    .head  (fifo_head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    is        = NOP_INSTR;
    pc_plus4F = '0;
    if_valid  = 1'b0;
    if (!fifo_empty && !redirect) begin
      is        = fifo_head.instr;
      pc_plus4F = fifo_head.pc + 32'd4;
      if_valid  = 1'b1;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        if_idwrite;
  logic [31:0] is;
  logic [31:0] pc_plus4F;
  logic        if_valid;
`ifdef IF_MISALIGN_TRAP_EN
  logic        if_misalign;
`endif

  always #5 clk = ~clk;

  if_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_idwrite  (if_idwrite),
    .is          (is),
    .pc_plus4F   (pc_plus4F),
    .if_valid    (if_valid)
`ifdef IF_MISALIGN_TRAP_EN
    ,
    .if_misalign (if_misalign)
`endif
  );

  // Instruction memory contents: word at 0x3000 is 0x20080001.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h2008_3001;
  endfunction

  // ---------------- memory responder ----------------
  int          cyc = 0, granted = 0, budget = 0, lat = 1;
  logic        gnt_en = 1'b0, ghost = 1'b0, resp_rv = 1'b0;
  logic [31:0] resp_rdata = 32'h0;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  assign imem_gnt    = gnt_en && (granted < budget);
  assign imem_rvalid = resp_rv | ghost;
  assign imem_rdata  = resp_rdata;

  always @(posedge clk) begin : responder
    logic        hs, rv;
    logic [31:0] a;
    hs = imem_req && imem_gnt;
    a  = imem_addr;
    rv = resp_rv;
    #1;
    cyc = cyc + 1;
    if (rv && pend_addr.size() != 0) begin
      pend_addr.delete(0);
      pend_due.delete(0);
    end
    if (hs) begin
      pend_addr.push_back(a);
      pend_due.push_back(cyc + lat);
      granted = granted + 1;
    end
    if (pend_addr.size() != 0 && pend_due[0] <= cyc + 1) begin
      resp_rv    = 1'b1;
      resp_rdata = mem_word(pend_addr[0]);
    end else begin
      resp_rv    = 1'b0;
      resp_rdata = 32'hDEAD_BEEF;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } exp_t;

  exp_t expq[$];
  int   n_pass = 0, n_total = 0;
  bit   done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic expect_word(input logic [31:0] pc, input logic [31:0] pcp4);
    exp_t e;
    e.instr = mem_word(pc);
    e.pcp4  = pcp4;
    expq.push_back(e);
  endtask

  task automatic mon_loop();
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (!reset && if_valid && if_idwrite && !redirect) begin
        if (expq.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_output: is=%h pc_plus4F=%h", is, pc_plus4F);
        end else begin
          e = expq.pop_front();
          chk("is", is, e.instr);
          chk("pc_plus4F", pc_plus4F, e.pcp4);
        end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wait_grants();
    int t = 0;
    while (granted != budget && t < 100) begin step(); t++; end
    if (granted != budget) begin
      n_total++;
      $display("FAIL grant_timeout: granted %0d needed %0d", granted, budget);
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (expq.size() != 0 && t < 300) begin step(); t++; end
    if (expq.size() != 0) begin
      n_total++;
      $display("FAIL %s_drain_timeout: %0d words never presented", name, expq.size());
      expq.delete();
    end
    step(2);
    chk({name, "_idle"}, if_valid, 1'b0);
  endtask

  task automatic pulse_redirect(input logic [31:0] tgt);
    redirect = 1'b1; redirect_pc = tgt;
    step();
    redirect = 1'b0;
  endtask

  task automatic main_seq();
    int t;
    reset = 1'b1; redirect = 1'b0; redirect_pc = 32'h0; if_idwrite = 1'b0;
    step(3);
    chk("rst_req",   imem_req,  1'b0);
    chk("rst_is",    is,        32'h0);
    chk("rst_pcp4",  pc_plus4F, 32'h0);
    chk("rst_valid", if_valid,  1'b0);

    // Sequential fetch from reset with 1-cycle returns.
    gnt_en = 1'b1; lat = 1; budget = 6; if_idwrite = 1'b1;
    for (int i = 0; i < 6; i++) expect_word(32'h3000 + 4*i, 32'h3004 + 4*i);
    reset = 1'b0;
    #1;
    chk("a_req",   imem_req,  1'b1);
    chk("a_addr0", imem_addr, 32'h3000);
    step();
    chk("a_addr1",  imem_addr, 32'h3004);
    chk("a_bubble", if_valid,  1'b0);
    step();
    chk("a_is0",   is,        32'h2008_0001);
    chk("a_pcp4",  pc_plus4F, 32'h3004);
    drain("a");

    // ID stall: buffer fills, requests stop, head holds.
    if_idwrite = 1'b0; budget += 4;
    step(5);
    chk("b_req_off", imem_req,  1'b0);
    chk("b_is",      is,        32'h2008_0019);
    chk("b_pcp4",    pc_plus4F, 32'h301C);
    step();
    chk("b_is_hold",   is,        32'h2008_0019);
    chk("b_pcp4_hold", pc_plus4F, 32'h301C);
    for (int i = 0; i < 4; i++) expect_word(32'h3018 + 4*i, 32'h301C + 4*i);
    if_idwrite = 1'b1;
    drain("b");

    // Redirect with a full buffer: output forced to bubble, buffer flushed.
    if_idwrite = 1'b0; budget += 2;
    step(5);
    chk("b2_full", if_valid, 1'b1);
    redirect = 1'b1; redirect_pc = 32'h3080;
    #1;
    chk("b2_redir_is",    is,        32'h0);
    chk("b2_redir_pcp4",  pc_plus4F, 32'h0);
    chk("b2_redir_valid", if_valid,  1'b0);
    chk("b2_redir_req",   imem_req,  1'b0);
    step();
    redirect = 1'b0;
    chk("b2_flushed", if_valid, 1'b0);
    budget += 1;
    expect_word(32'h3080, 32'h3084);
    if_idwrite = 1'b1;
    drain("b2");

    // Redirect with two requests in flight: both returns discarded.
    lat = 4; budget += 2;
    wait_grants();
    redirect = 1'b1; redirect_pc = 32'h3100;
    #1;
    chk("c_redir_req", imem_req, 1'b0);
    chk("c_redir_is",  is,       32'h0);
    step();
    redirect = 1'b0; lat = 1; budget += 2;
    expect_word(32'h3100, 32'h3104);
    expect_word(32'h3104, 32'h3108);
    drain("c");

    // Back-to-back redirects: last target wins.
    lat = 3; budget += 2;
    wait_grants();
    pulse_redirect(32'h3200);
    redirect = 1'b1; redirect_pc = 32'h3300;
    step();
    redirect = 1'b0; lat = 1; budget += 2;
    expect_word(32'h3300, 32'h3304);
    expect_word(32'h3304, 32'h3308);
    drain("c2");

    // Grant withheld: request and address hold steady.
    gnt_en = 1'b0; budget += 1;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("d_req_held",  imem_req,  1'b1);
      chk("d_addr_held", imem_addr, 32'h3308);
      step();
    end
    gnt_en = 1'b1;
    expect_word(32'h3308, 32'h330C);
    drain("d");

`ifdef IF_MISALIGN_TRAP_EN
    pulse_redirect(32'h3102);
    chk("m_flag_set", if_misalign, 1'b1);
    chk("m_req_off",  imem_req,    1'b0);
    budget += 1;
    step(3);
    chk("m_req_halted", imem_req, 1'b0);
    chk("m_is_nop",     is,       32'h0);
    pulse_redirect(32'h3100);
    chk("m_flag_clr", if_misalign, 1'b0);
    expect_word(32'h3100, 32'h3104);
    drain("m");
`else
    // Low target bits are ignored.
    pulse_redirect(32'h3102);
    budget += 1;
    expect_word(32'h3100, 32'h3104);
    drain("m");
`endif

    // Fetch PC wraps past the top of the address space.
    pulse_redirect(32'hFFFF_FFF8);
    budget += 3;
    expect_word(32'hFFFF_FFF8, 32'hFFFF_FFFC);
    expect_word(32'hFFFF_FFFC, 32'h0000_0000);
    expect_word(32'h0000_0000, 32'h0000_0004);
    drain("e");

    // Reset mid-transfer; late and spurious returns are ignored.
    if_idwrite = 1'b0; lat = 3; budget += 2;
    wait_grants();
    reset = 1'b1; gnt_en = 1'b0;
    step();
    chk("f_rst_req",   imem_req, 1'b0);
    chk("f_rst_valid", if_valid, 1'b0);
    reset = 1'b0;
    t = 0;
    while (pend_addr.size() != 0 && t < 20) begin step(); t++; end
    step(2);
    chk("f_post_valid", if_valid,  1'b0);
    chk("f_post_req",   imem_req,  1'b1);
    chk("f_post_addr",  imem_addr, 32'h3000);
    ghost = 1'b1;
    step();
    ghost = 1'b0;
    step();
    chk("f_ghost_ignored", if_valid, 1'b0);
    gnt_en = 1'b1; budget += 1; if_idwrite = 1'b1;
    expect_word(32'h3000, 32'h3004);
    drain("f");

    done = 1'b1;
  endtask

  initial begin
    fork
      mon_loop();
      main_seq();
    join
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
